// File: rtl/debug_sequencer.sv
// Host-side debug controller: decodes UART command bytes, loads instruction memory,
// sequences run/step through the stall line and streams register/latch snapshots back.
module debug_sequencer #(
  parameter int SIZE            = 32,
  parameter int IF_ID_SIZE      = 32,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 77,
  parameter int MEM_WB_SIZE     = 71,
  parameter int MAX_INSTRUCTION = 64,
  parameter int NUM_REGISTERS   = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [7:0]                         i_rx_data,
  input  logic                               i_rx_valid,
  output logic [7:0]                         o_tx_data,
  output logic                               o_tx_start,
  input  logic                               i_tx_done,
  output logic                               o_imem_we,
  output logic [$clog2(MAX_INSTRUCTION)-1:0] o_imem_addr,
  output logic [SIZE-1:0]                    o_imem_data,
  output logic                               o_pipe_rst,
  output logic                               o_stall,
  input  logic                               i_halt,
  output logic [$clog2(NUM_REGISTERS)-1:0]   o_reg_addr,
  input  logic [SIZE-1:0]                    i_reg_data,
  input  logic [IF_ID_SIZE-1:0]              i_if_id,
  input  logic [ID_EX_SIZE-1:0]              i_id_ex,
  input  logic [EX_MEM_SIZE-1:0]             i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0]             i_mem_wb,
  output logic                               o_step_mode,
  output logic                               o_busy
);

  localparam int IMEM_AW = $clog2(MAX_INSTRUCTION);
  localparam int REG_AW  = $clog2(NUM_REGISTERS);
  localparam int W_A     = (IF_ID_SIZE > ID_EX_SIZE) ? IF_ID_SIZE : ID_EX_SIZE;
  localparam int W_B     = (EX_MEM_SIZE > MEM_WB_SIZE) ? EX_MEM_SIZE : MEM_WB_SIZE;
  localparam int W_C     = (W_A > W_B) ? W_A : W_B;
  localparam int W_MAX   = (W_C > SIZE) ? W_C : SIZE;
  localparam int SHIFT_W = ((W_MAX + 7) / 8) * 8;

  localparam logic [4:0] NB_IF_ID  = 5'((IF_ID_SIZE + 7) / 8 - 1);
  localparam logic [4:0] NB_ID_EX  = 5'((ID_EX_SIZE + 7) / 8 - 1);
  localparam logic [4:0] NB_EX_MEM = 5'((EX_MEM_SIZE + 7) / 8 - 1);
  localparam logic [4:0] NB_MEM_WB = 5'((MEM_WB_SIZE + 7) / 8 - 1);
  localparam logic [7:0] RESP_OK   = 8'h52;
  localparam logic [7:0] RESP_ERR  = 8'h45;

  typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_DATA, DUMP, TX_BYTE, TX_WAIT} state_t;

  state_t               state;
  logic [SHIFT_W-1:0]   shift;
  logic [4:0]           bytes_left;
  logic                 resp_pending;
  logic                 reg_dump;
  logic [REG_AW:0]      words_left;
  logic [23:0]          word_buf;
  logic [1:0]           byte_idx;
  logic [IMEM_AW-1:0]   load_idx;
  logic [IMEM_AW-1:0]   load_last;
  logic                 running;
  logic                 started;

  // shift holds the byte currently on o_tx_data in its low byte; bytes_left counts what follows it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      shift        <= '0;
      bytes_left   <= '0;
      resp_pending <= 1'b0;
      reg_dump     <= 1'b0;
      words_left   <= '0;
      word_buf     <= '0;
      byte_idx     <= '0;
      load_idx     <= '0;
      load_last    <= '0;
      running      <= 1'b0;
      started      <= 1'b0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_pipe_rst   <= 1'b0;
      o_stall      <= 1'b1;
      o_reg_addr   <= '0;
      o_step_mode  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_imem_we  <= 1'b0;
      o_pipe_rst <= 1'b0;
      o_stall    <= ~(running & ~i_halt);

      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            o_busy       <= 1'b1;
            state        <= DUMP;
            o_tx_data    <= RESP_OK;
            bytes_left   <= '0;
            resp_pending <= 1'b0;
            reg_dump     <= 1'b0;
            case (i_rx_data)
              8'h01: begin
                reg_dump     <= 1'b1;
                o_reg_addr   <= '0;
                words_left   <= (REG_AW+1)'(NUM_REGISTERS - 1);
                resp_pending <= 1'b1;
              end
              8'h02: begin
                shift <= SHIFT_W'(i_if_id);  o_tx_data <= i_if_id[7:0];
                bytes_left <= NB_IF_ID;      resp_pending <= 1'b1;
              end
              8'h03: begin
                shift <= SHIFT_W'(i_id_ex);  o_tx_data <= i_id_ex[7:0];
                bytes_left <= NB_ID_EX;      resp_pending <= 1'b1;
              end
              8'h04: begin
                shift <= SHIFT_W'(i_ex_mem); o_tx_data <= i_ex_mem[7:0];
                bytes_left <= NB_EX_MEM;     resp_pending <= 1'b1;
              end
              8'h05: begin
                shift <= SHIFT_W'(i_mem_wb); o_tx_data <= i_mem_wb[7:0];
                bytes_left <= NB_MEM_WB;     resp_pending <= 1'b1;
              end
              8'h07: state <= LOAD_CNT;
              8'h08: o_step_mode <= 1'b0;
              8'h09, 8'h11: begin
                o_step_mode <= 1'b1;
                running     <= 1'b0;
              end
              8'h0D: begin
                o_pipe_rst <= 1'b1;
                started    <= 1'b1;
                if (!o_step_mode) running <= 1'b1;
              end
              // a halt arriving with the step command suppresses the step but still acknowledges
              8'h0A: begin
                if (o_step_mode && started) begin
                  if (!i_halt) o_stall <= 1'b0;
                end else begin
                  o_tx_data <= RESP_ERR;
                end
              end
              8'h0E: running <= 1'b0;
              default: o_tx_data <= RESP_ERR;
            endcase
          end
        end

        LOAD_CNT: begin
          if (i_rx_valid) begin
            if (i_rx_data != 8'd0 && {24'd0, i_rx_data} <= 32'(MAX_INSTRUCTION)) begin
              load_last <= IMEM_AW'(i_rx_data - 8'd1);
              load_idx  <= '0;
              byte_idx  <= '0;
              state     <= LOAD_DATA;
            end else begin
              o_tx_data <= RESP_ERR;
              state     <= DUMP;
            end
          end
        end

        LOAD_DATA: begin
          if (i_rx_valid) begin
            word_buf <= {i_rx_data, word_buf[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              o_imem_we   <= 1'b1;
              o_imem_addr <= load_idx;
              o_imem_data <= SIZE'({i_rx_data, word_buf});
              load_idx    <= load_idx + 1'b1;
              if (load_idx == load_last) begin
                o_tx_data <= RESP_OK;
                state     <= DUMP;
              end
            end
          end
        end

        DUMP: begin
          if (reg_dump) begin
            shift      <= SHIFT_W'(i_reg_data);
            o_tx_data  <= i_reg_data[7:0];
            bytes_left <= 5'd3;
            o_reg_addr <= o_reg_addr + 1'b1;
          end
          o_tx_start <= 1'b1;
          state      <= TX_BYTE;
        end

        TX_BYTE: state <= TX_WAIT;

        // the next register address is already presented, so its word is ready on tx_done
        TX_WAIT: begin
          if (i_tx_done) begin
            if (bytes_left != 5'd0) begin
              o_tx_data  <= shift[15:8];
              shift      <= shift >> 8;
              bytes_left <= bytes_left - 5'd1;
              o_tx_start <= 1'b1;
              state      <= TX_BYTE;
            end else if (reg_dump && words_left != '0) begin
              shift      <= SHIFT_W'(i_reg_data);
              o_tx_data  <= i_reg_data[7:0];
              bytes_left <= 5'd3;
              o_reg_addr <= o_reg_addr + 1'b1;
              words_left <= words_left - 1'b1;
              o_tx_start <= 1'b1;
              state      <= TX_BYTE;
            end else if (resp_pending) begin
              o_tx_data    <= RESP_OK;
              resp_pending <= 1'b0;
              o_tx_start   <= 1'b1;
              state        <= TX_BYTE;
            end else begin
              reg_dump <= 1'b0;
              o_busy   <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (i_halt) running <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed self-checking bench for debug_sequencer with a simple UART transmitter responder.
module tb_debug_sequencer;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [7:0]   i_rx_data = '0;
  logic         i_rx_valid = 1'b0;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic         i_tx_done = 1'b0;
  logic         o_imem_we;
  logic [5:0]   o_imem_addr;
  logic [31:0]  o_imem_data;
  logic         o_pipe_rst;
  logic         o_stall;
  logic         i_halt = 1'b0;
  logic [4:0]   o_reg_addr;
  logic [31:0]  i_reg_data;
  logic [31:0]  i_if_id = '0;
  logic [128:0] i_id_ex = '0;
  logic [76:0]  i_ex_mem = '0;
  logic [70:0]  i_mem_wb = '0;
  logic         o_step_mode;
  logic         o_busy;

  debug_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_pipe_rst(o_pipe_rst), .o_stall(o_stall), .i_halt(i_halt),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .i_if_id(i_if_id), .i_id_ex(i_id_ex), .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb),
    .o_step_mode(o_step_mode), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  assign i_reg_data = 32'h100 + 32'(o_reg_addr);

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  logic [7:0]  tx_q[$];
  int          tx_t[$];
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_t[$];
  int          overlaps = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0] exp_idex [17] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE,
                                8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h01};
  logic [7:0] load_bytes [12] = '{8'h07, 8'h00, 8'h01, 8'h3C, 8'h05, 8'h00, 8'h02, 8'h3C,
                                  8'h08, 8'h00, 8'h20, 8'h00};

  always @(negedge i_clk) begin
    if (o_tx_start) begin
      tx_q.push_back(o_tx_data);
      tx_t.push_back(cyc);
    end
    if (o_imem_we) begin
      wr_addr.push_back(o_imem_addr);
      wr_data.push_back(o_imem_data);
      wr_t.push_back(cyc);
    end
  end

  // transmitter model: tx_done three cycles after each start, and no start may arrive meanwhile
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        repeat (2) begin
          @(negedge i_clk);
          if (o_tx_start) overlaps++;
        end
        @(posedge i_clk); #1 i_tx_done = 1'b1;
        @(negedge i_clk);
        if (o_tx_start) overlaps++;
        @(posedge i_clk); #1 i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    tick();
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    t = cyc;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (o_busy && k < 2000) begin
      tick();
      k++;
    end
    check(tag, o_busy, 0);
    repeat (3) tick();
  endtask

  initial begin
    int t, h, base, wbase, bad, n;
    logic [7:0] e;

    repeat (3) tick();
    check("reset_ctrl", {o_tx_start, o_imem_we, o_pipe_rst, o_step_mode, o_busy, o_stall}, 6'b000001);
    check("reset_data", {o_tx_data, o_imem_addr, o_reg_addr, o_imem_data}, '0);
    i_rst = 1'b0;
    tick();

    // program load of three words
    base = tx_q.size(); wbase = wr_q_size();
    send_byte(8'h07, t);
    send_byte(8'h03, t);
    for (int i = 0; i < 12; i++) send_byte(load_bytes[i], t);
    wait_idle("load_idle");
    check("load_nwrites", wr_addr.size() - wbase, 3);
    check("load_w0", {wr_addr[wbase], wr_data[wbase]}, {6'd0, 32'h3C010007});
    check("load_w1", {wr_addr[wbase+1], wr_data[wbase+1]}, {6'd1, 32'h3C020005});
    check("load_w2", {wr_addr[wbase+2], wr_data[wbase+2]}, {6'd2, 32'h00200008});
    check("load_we_time", wr_t[wbase+2], t + 1);
    check("load_ntx", tx_q.size() - base, 1);
    check("load_resp", tx_q[base], 8'h52);
    check("load_resp_time", tx_t[base], t + 2);

    // invalid counts
    base = tx_q.size(); wbase = wr_q_size();
    send_byte(8'h07, t);
    send_byte(8'h00, t);
    wait_idle("cnt0_idle");
    check("cnt0_ntx", tx_q.size() - base, 1);
    check("cnt0_resp", tx_q[base], 8'h45);
    check("cnt0_resp_time", tx_t[base], t + 2);
    base = tx_q.size();
    send_byte(8'h07, t);
    send_byte(8'h41, t);
    wait_idle("cnt65_idle");
    check("cnt65_resp", tx_q[base], 8'h45);
    check("cnt_no_writes", wr_addr.size() - wbase, 0);

    // ID/EX snapshot, input disturbed mid-dump
    base = tx_q.size();
    i_id_ex = 129'h1_0123456789ABCDEF_FEDCBA9876543210;
    send_byte(8'h03, t);
    tick(); tick();
    i_id_ex = '1;
    wait_idle("idex_idle");
    check("idex_ntx", tx_q.size() - base, 18);
    check("idex_first_time", tx_t[base], t + 2);
    check("idex_spacing", tx_t[base+1] - tx_t[base], 4);
    bad = 0;
    for (int i = 0; i < 17; i++) if (tx_q[base+i] !== exp_idex[i]) bad++;
    check("idex_bytes_bad", bad, 0);
    check("idex_top_byte", tx_q[base+16], 8'h01);
    check("idex_resp", tx_q[base+17], 8'h52);

    // MEM/WB snapshot: 71 bits pad the top byte with zeros
    base = tx_q.size();
    i_mem_wb = '1;
    send_byte(8'h05, t);
    wait_idle("memwb_idle");
    check("memwb_ntx", tx_q.size() - base, 10);
    check("memwb_byte7", tx_q[base+7], 8'hFF);
    check("memwb_byte8", tx_q[base+8], 8'h7F);
    check("memwb_resp", tx_q[base+9], 8'h52);

    // step mode sequencing
    base = tx_q.size();
    send_byte(8'h11, t);
    wait_idle("stepm_idle");
    check("stepm_mode", o_step_mode, 1);
    check("stepm_resp", tx_q[base], 8'h52);
    base = tx_q.size();
    send_byte(8'h0A, t);
    wait_idle("step_early_idle");
    check("step_early_resp", tx_q[base], 8'h45);
    base = tx_q.size();
    send_byte(8'h0D, t);
    check("stepstart_rst_t1", {o_pipe_rst, o_stall}, 2'b11);
    tick();
    check("stepstart_rst_t2", {o_pipe_rst, o_stall}, 2'b01);
    wait_idle("stepstart_idle");
    check("stepstart_resp", tx_q[base], 8'h52);
    base = tx_q.size();
    send_byte(8'h0A, t);
    check("step_stall_t1", o_stall, 0);
    tick();
    check("step_stall_t2", o_stall, 1);
    wait_idle("step_idle");
    check("step_resp", tx_q[base], 8'h52);

    // halt coincident with step: no step, still acknowledged
    base = tx_q.size();
    tick();
    i_rx_data = 8'h0A; i_rx_valid = 1'b1; i_halt = 1'b1;
    tick();
    i_rx_valid = 1'b0; i_halt = 1'b0;
    check("step_halt_stall", o_stall, 1);
    wait_idle("step_halt_idle");
    check("step_halt_resp", tx_q[base], 8'h52);

    // register dump, with a command byte dropped while busy
    base = tx_q.size();
    send_byte(8'h01, t);
    repeat (10) tick();
    send_byte(8'h08, h);
    wait_idle("regs_idle");
    check("regs_drop_mode", o_step_mode, 1);
    check("regs_ntx", tx_q.size() - base, 129);
    check("regs_first_time", tx_t[base], t + 2);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      e = ((i % 4) == 0) ? 8'(i / 4) : (((i % 4) == 1) ? 8'h01 : 8'h00);
      if (tx_q[base+i] !== e) bad++;
    end
    check("regs_bytes_bad", bad, 0);
    check("regs_byte124", tx_q[base+124], 8'h1F);
    check("regs_resp", tx_q[base+128], 8'h52);

    // continuous run, halt, restart, stop
    base = tx_q.size();
    send_byte(8'h08, t);
    wait_idle("cont_idle");
    check("cont_mode", o_step_mode, 0);
    send_byte(8'h0D, t);
    check("run_t1", {o_pipe_rst, o_stall}, 2'b11);
    tick();
    check("run_t2", {o_pipe_rst, o_stall}, 2'b00);
    wait_idle("run_idle");
    check("run_still", o_stall, 0);
    tick();
    i_halt = 1'b1;
    h = cyc;
    tick();
    i_halt = 1'b0;
    check("halt_stall", o_stall, 1);
    check("halt_time", cyc, h + 1);
    send_byte(8'h0D, t);
    wait_idle("rerun_idle");
    check("rerun_stall", o_stall, 0);
    send_byte(8'h0E, t);
    tick();
    check("stop_stall", o_stall, 1);
    wait_idle("stop_idle");
    check("cont_resps", {tx_q[base], tx_q[base+1], tx_q[base+2], tx_q[base+3]}, 32'h52525252);

    // reset in the middle of a register dump
    base = tx_q.size();
    send_byte(8'h01, t);
    n = 0;
    while (tx_q.size() < base + 20 && n < 500) begin
      tick();
      n++;
    end
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    n = tx_q.size();
    repeat (40) tick();
    check("rst_mid_count", n - base, 20);
    check("rst_mid_no_tx", tx_q.size(), n);
    check("rst_mid_state", {o_stall, o_busy, o_step_mode}, 3'b100);

    check("tx_overlaps", overlaps, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int wr_q_size();
    return wr_addr.size();
  endfunction

endmodule

// File: doc/debug_sequencer.md
# debug_sequencer

Host-side debug controller for the MIPS pipeline. It decodes command bytes from the UART receiver and loads programs into instruction memory. It sequences execution in continuous or step-by-step mode through the pipeline stall line, and serializes register-file and pipeline-latch snapshots back through the UART transmitter. It sits between the `uart_rx`/`uart_tx` pair and the `mips` core.

## Interface
- `SIZE`, 32, data/instruction word width
- `IF_ID_SIZE`, 32, IF/ID latch width
- `ID_EX_SIZE`, 129, ID/EX latch width
- `EX_MEM_SIZE`, 77, EX/MEM latch width
- `MEM_WB_SIZE`, 71, MEM/WB latch width
- `MAX_INSTRUCTION`, 64, instruction memory depth in words
- `NUM_REGISTERS`, 32, register file depth

Ports:
- `i_clk`  in  1  the single clock.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle pulse per received byte.
- `o_tx_data`  out  8  byte to transmit.
- `o_tx_start`  out  1  one-cycle pulse launching `o_tx_data`.
- `i_tx_done`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `o_imem_we`  out  1  instruction memory write strobe.
- `o_imem_addr`  out  $clog2(MAX_INSTRUCTION)  word address.
- `o_imem_data`  out  SIZE  word to write.
- `o_pipe_rst`  out  1  one-cycle pipeline/PC reset pulse.
- `o_stall`  out  1  1 holds every pipeline stage.
- `i_halt`  in  1  core reached end of program.
- `o_reg_addr`  out  $clog2(NUM_REGISTERS)  debug read address.
- `i_reg_data`  in  SIZE  combinational register read data.
- `i_if_id`, `i_id_ex`, `i_ex_mem`, `i_mem_wb`  in  respective `*_SIZE`  live latch contents.
- `o_step_mode`  out  1  1 = step-by-step, 0 = continuous.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, LOAD_CNT, LOAD_DATA, DUMP, TX_BYTE, TX_WAIT.
- **Response rule:** every accepted command ends by transmitting 'R' (0x52). An unknown command byte, or an invalid load count, transmits 'E' (0x45).
- **Command set, decoded in IDLE on `i_rx_valid`:**
  - 0x01: dump registers 0..NUM_REGISTERS-1, 4 bytes each, LSB first (128 bytes), then 'R'.
  - 0x02/0x03/0x04/0x05: snapshot IF/ID / ID/EX / EX/MEM / MEM/WB and send ceil(W/8) bytes LSB-first (4/17/10/9 at defaults), zero-padded in the top byte, then 'R'.
  - 0x07: go to LOAD_CNT.
    - Next byte is N. If N=0 or N>MAX_INSTRUCTION, send 'E' and return to IDLE.
    - Otherwise LOAD_DATA receives 4N bytes; each group of 4 is assembled little-endian into word k, for k = 0..N-1.
    - After word N-1 is written, send 'R'.
  - 0x08: continuous mode (`o_step_mode`=0). 0x09 or 0x11: step mode (`o_step_mode`=1). Either way, send 'R'.
  - 0x0D: pulse `o_pipe_rst`.
    - Continuous mode: set `running` (`o_stall`=0).
    - Step mode: the pipeline stays stalled.
    - Send 'R'.
  - 0x0A: only in step mode with the program started. `o_stall`=0 for exactly one cycle, then 'R'. Otherwise 'E'.
  - 0x0E: clear `running`, then 'R'.
- **Halt:** `i_halt`=1 clears `running` in any state.
- **Register dump:** `o_reg_addr` steps 0..NUM_REGISTERS-1. Each word is captured the cycle after its address is presented.
- **Latch snapshots:** captured once at command accept into a shift register. Later pipeline motion does not alter the bytes sent.
- **Transmit handshake:** TX_BYTE asserts `o_tx_start` for 1 cycle, then TX_WAIT waits for `i_tx_done`. Bytes are never overlapped.
- **Dropped input:** `i_rx_valid` in DUMP/TX_BYTE/TX_WAIT is dropped.
- **No load timeout:** LOAD_CNT/LOAD_DATA wait for bytes indefinitely.

## Timing
- **Reset values:**
  - 0: `o_tx_start`, `o_imem_we`, `o_pipe_rst`, `o_step_mode`, `o_busy`, `o_reg_addr`, `o_tx_data`, `o_imem_addr`, `o_imem_data`, and `running`.
  - 1: `o_stall`.
  - State after reset: IDLE.
- **Reset mid-operation:** any partial load or dump is abandoned and no further `o_tx_start` is issued. Words already written remain in memory.
- **Command response:** command byte valid at cycle t → first `o_tx_start` at t+2 (snapshot taken at t+1).
- **Byte spacing:** next `o_tx_start` comes 1 cycle after the previous `i_tx_done`.
- **Memory write:** 4th byte of word k valid at t → `o_imem_we`=1 at t+1 with `o_imem_addr`=k. The 'R' `o_tx_start` follows at t+2 for the last word.
- **Start (0x0D):** `o_pipe_rst` high at t+1. `o_stall` falls at t+2 in continuous mode.
- **Step (0x0A):** `o_stall`=0 during cycle t+1 only.
- **Halt:** `i_halt` at t → `o_stall`=1 at t+1.
- **Simultaneous `i_halt` and 0x0A:** the halt wins and no step occurs; 'R' is still sent.

## Test plan
- **Load:** 0x07, 0x03, then 12 bytes encoding 0x3C010007, 0x3C020005, 0x00200008 → writes at addresses 0,1,2 with those words, then a single 'R'.
- **Invalid count:** 0x07, 0x00 → 'E', no `o_imem_we`. Then 0x07, 0x41 (65 > 64) → 'E'.
- **ID/EX dump:** `i_id_ex` = 129'h1_0123456789ABCDEF_FEDCBA9876543210, 0x03 → bytes 10 32 54 76 98 BA DC FE EF CD AB 89 67 45 23 01 01, then 'R'. The input changing mid-dump has no effect on the bytes.
- **Step sequencing:** 0x11, 0x0D, 0x0A → `o_pipe_rst` pulse, `o_stall` low for exactly 1 cycle, three 'R' replies. 0x0A sent before 0x0D → 'E'.
- **Continuous run:** 0x08, 0x0D → `o_stall`=0 until `i_halt` pulses, then 1 the next cycle. 0x0E while running → `o_stall`=1.
- **Register dump:** `i_reg_data` = 0x100+addr, 0x01 → 128 bytes ordered 00 01 00 00, 01 01 00 00, …, 1F 01 00 00, then 'R'. Reset asserted after byte 20 → `o_tx_start` stays 0 and `o_stall`=1.
